// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants and the output arbiter state encoding
package noc_pkg;
  localparam int NUM_PORTS = 5;
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_PE = 4;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/output_port_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first request above ptr
module rr_priority_picker #(
  parameter int N = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             any_req
);
  logic [PTR_W:0] sh;
  logic [N-1:0] rot;
  logic [N-1:0] rot_win;
  logic [2*N-1:0] dbl_win;
  assign sh = {1'b0, ptr} + (PTR_W+1)'(1);
  assign rot = N'({req, req} >> sh);
  assign rot_win = rot & (~rot + N'(1));
  assign dbl_win = {rot_win, rot_win} << sh;
  assign winner = dbl_win[2*N-1:N];
  assign any_req = |req;
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: packet-granular round-robin output allocation; ARB_TIMEOUT_EN adds an owner-idle release
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int PTR_W = 3
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 xfer,
  output logic                 busy
`ifdef ARB_TIMEOUT_EN
  , output logic               timeout
`endif
);
  arb_state_t state, state_nx;
  logic [NUM_PORTS-1:0] grant_nx, winner;
  logic [PTR_W-1:0] rr_ptr, ptr_nx, owner;
  logic any_req, own_req, own_tail, done;
  rr_priority_picker #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_pick (
    .req(req),
    .ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  assign busy = state == ARB_BUSY;
  assign own_req = |(req & grant);
  assign own_tail = |(tail & grant);
  assign xfer = busy & out_ready & own_req;
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;
  assign timeout = busy & ~own_req & (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done = (xfer & own_tail) | timeout;
  // count consecutive owner-idle cycles; cleared while idle so a new grant starts at zero
  always_ff @(posedge clk)
    if (rst | ~busy | own_req) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + CNT_W'(1);
`else
  assign done = xfer & own_tail;
`endif
  // encode the one-hot owner so the pointer can park on it at release
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) owner = PTR_W'(i);
  end
  // allocate from IDLE, hold through the packet, release on tail (or timeout)
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx = rr_ptr;
    if (state == ARB_IDLE) begin
      state_nx = any_req ? ARB_BUSY : ARB_IDLE;
      grant_nx = winner;
    end else if (done) begin
      state_nx = ARB_IDLE;
      grant_nx = '0;
      ptr_nx = owner;
    end
  end
  // state register; pointer starts at the last port so port 0 wins first
  always_ff @(posedge clk)
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      rr_ptr <= PTR_W'(NUM_PORTS - 1);
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      rr_ptr <= ptr_nx;
    end
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- One instance per router output port (North, East, South, West, PE-out).
- Collects the per-input request lines from the five request generators.
- Grants the output to one input using round-robin priority and holds the grant for a whole packet (head to tail flit), so flits of different packets never interleave.
- Drives the one-hot select for the output crossbar mux and the per-flit transfer strobe.

Parameters:
- NUM_PORTS, 5, number of input ports competing (index 0=N, 1=E, 2=S, 3=W, 4=PE).
- PTR_W, 3, width of the round-robin pointer; must satisfy 2**PTR_W >= NUM_PORTS.
- TIMEOUT_CYCLES, 16, owner-idle limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Synchronous, active-high reset.
- req  input  NUM_PORTS  Bit i high: input i has a flit at its buffer head destined for this output.
- tail  input  NUM_PORTS  Bit i high: the flit at input i's head is a tail flit (a single-flit packet sets tail on its head flit).
- out_ready  input  1  Downstream buffer not full; a flit may move this cycle.
- grant  output  NUM_PORTS  One-hot registered owner select; all zero when idle.
- xfer  output  1  A flit moves from the owner to the output this cycle.
- busy  output  1  The output is allocated to a packet.

Behaviour:
- Reset: state=IDLE, grant=0, busy=0, rr_ptr=NUM_PORTS-1 (so input 0 has first priority). xfer=0, because it is derived from busy.
- FSM has two states.
- IDLE:
  - If req is non-zero, pick the winner: the first set bit of req searching upward from rr_ptr+1 modulo NUM_PORTS.
  - Register grant=onehot(winner), busy=1, go to BUSY.
  - If req is zero, stay in IDLE.
  - Latency: request to grant is 1 cycle.
- BUSY:
  - xfer = busy & out_ready & req[owner], combinational from registered grant.
  - If xfer & tail[owner]: next cycle grant=0, busy=0, rr_ptr=owner, go to IDLE.
  - Otherwise hold grant unchanged.
- Every packet release therefore costs one IDLE bubble cycle; back-to-back packets are granted every other cycle at best.
- While BUSY, requests from non-owners are ignored and the grant never changes mid-packet.
- Owner req low while BUSY (bubble in the packet): hold the grant, xfer=0.
- out_ready low: xfer=0, grant held, no state change.
- Several requests in IDLE: exactly one winner, chosen by round-robin order.
- rr_ptr updates only on a packet release, never on a grant.
- rst asserted mid-packet: return to reset values the next edge regardless of xfer or tail. No partial state survives.
- grant is always one-hot or zero. Any other value is a design error, and the bench asserts on it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) counts consecutive BUSY cycles with req[owner]=0.
  - The counter resets on every cycle where req[owner]=1 and on every grant.
  - When it reaches TIMEOUT_CYCLES, force release exactly as a tail release (grant=0, rr_ptr=owner, IDLE) and pulse an extra output, timeout (1 bit), for one cycle.
- Not defined:
  - No counter and no timeout port exist.
  - The grant is held indefinitely until the tail is transferred.

Decomposition:
- Shared package noc_pkg holds:
  - the port index constants PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_PE=4;
  - NUM_PORTS;
  - the FSM state encoding typedef arb_state_t {ARB_IDLE, ARB_BUSY}.
- Natural sub-module: rr_priority_picker. It is purely combinational: inputs req and ptr; outputs a one-hot winner and an any_req flag. It is reused by the other four output arbiters.

Test Plan:
- After reset, req=5'b10001, tail=5'b00001, out_ready=1 -> grant=5'b00001 at cycle 1; xfer=1 at cycle 1; release at cycle 2 with rr_ptr=0.
- Next, hold req=5'b10001 -> grant=5'b10000 (PE) next: round-robin skips input 0.
- Granted input 2, 4-flit packet, tail high only on the 4th flit, req=5'b11111 throughout -> grant stays 5'b00100 for all 4 transfers; next winner is input 3.
- Owner mid-packet with out_ready held low for 3 cycles -> xfer=0 for those 3 cycles, grant unchanged; transfers resume when out_ready=1.
- rst pulsed for 1 cycle during the 2nd flit of a packet -> next cycle grant=0, busy=0, rr_ptr=4; a following req=5'b00010 is granted to input 1.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: owner drops req for 16 cycles -> timeout pulses once, grant=0, and a waiting requester is granted the following cycle.
